// File: rtl/sw_chan_pkg.sv
// Shared types and channel-stepping helpers for the switch-channel scan controller.
// SW_CHAN_SKIP_MCU_EN removes channels 14/15 from every stepping path.
package sw_chan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        DWELL,
        REQ,
        RELEASE,
        NEXT,
        FIN
    } state_e;

    localparam logic [7:0] SKIP_CH_LO = 8'd14;
    localparam logic [7:0] SKIP_CH_HI = 8'd15;

`ifdef SW_CHAN_SKIP_MCU_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    // Nearest legal channel at or above c.
    function automatic logic [7:0] chan_legal(input logic [7:0] c);
        logic [7:0] r;
        r = c;
        if (SKIP_EN && (c == SKIP_CH_LO || c == SKIP_CH_HI)) begin
            r = SKIP_CH_HI + 8'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] chan_next(input logic [7:0] c, input logic [7:0] lo,
                                             input logic [7:0] hi, input logic wrap);
        logic [7:0] n;
        if (c >= hi) begin
            n = wrap ? lo : c;
        end else begin
            n = c + 8'd1;
            if (SKIP_EN && n == SKIP_CH_LO) begin
                n = SKIP_CH_HI + 8'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] chan_prev(input logic [7:0] c, input logic [7:0] lo,
                                             input logic [7:0] hi, input logic wrap);
        logic [7:0] n;
        if (c <= lo) begin
            n = wrap ? hi : c;
        end else begin
            n = c - 8'd1;
            if (SKIP_EN && n == SKIP_CH_HI) begin
                n = SKIP_CH_LO - 8'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/sw_chan_scan_ctrl_debounce.sv
// Two-flop synchroniser, stable-sample debouncer and one-cycle press pulse for a momentary switch.
module sw_debounce #(
    parameter int unsigned DB_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    localparam int unsigned CNT_W = (DB_CYC < 2) ? 1 : $clog2(DB_CYC);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYC - 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Level follows the synchronised input only after DB_CYC consecutive differing samples.
    always_comb begin
        sync_d  = {sync_q[0], raw};
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = sync_q[1];
                rise_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/sw_chan_scan_ctrl.sv
// Switch-channel select owner: debounced manual stepping in IDLE, triggered auto scan otherwise.
// Build option SW_CHAN_SKIP_MCU_EN keeps channels 14/15 out of every selection.
module sw_chan_scan_ctrl
    import sw_chan_pkg::*;
#(
    parameter int unsigned CH_MIN    = 0,
    parameter int unsigned CH_MAX    = 4,
    parameter int unsigned CH_DEF    = 0,
    parameter int unsigned WRAP_EN   = 1,
    parameter int unsigned DB_CYC    = 1000,
    parameter int unsigned DWELL_CYC = 256,
    parameter int unsigned TMO_CYC   = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       up_raw,
    input  logic       dn_raw,
    input  logic       auto_start,
    input  logic       abort,
    input  logic       meas_ack,
    output logic [7:0] chan,
    output logic       chan_vld,
    output logic       meas_req,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] CH_LO    = chan_legal(8'(CH_MIN));
    localparam logic [7:0] CH_HI    = chan_legal(8'(CH_MAX));
    localparam logic [7:0] CH_DEF_L = chan_legal(8'(CH_DEF));
    localparam logic       WRAP     = (WRAP_EN != 0);
    localparam logic       TMO_EN   = (TMO_CYC != 0);

    localparam int unsigned DW_W  = (DWELL_CYC < 2) ? 1 : $clog2(DWELL_CYC);
    localparam int unsigned TMO_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);
    localparam int unsigned CNT_W = (DW_W > TMO_W) ? DW_W : TMO_W;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'((TMO_CYC == 0) ? 0 : TMO_CYC - 1);

    state_e           state_q, state_d;
    logic [7:0]       chan_q, chan_d;
    logic             chan_vld_q, chan_vld_d;
    logic             meas_req_q, meas_req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       step_c;
    logic             up_press_c, dn_press_c;

    sw_debounce #(.DB_CYC(DB_CYC)) u_db_up (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (up_raw),
        .rise (up_press_c)
    );

    sw_debounce #(.DB_CYC(DB_CYC)) u_db_dn (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (dn_raw),
        .rise (dn_press_c)
    );

    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        chan_vld_d = 1'b0;
        meas_req_d = meas_req_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        step_c     = chan_q;

        unique case (state_q)
            IDLE: begin
                if (auto_start && !abort) begin
                    state_d    = SET;
                    chan_d     = CH_LO;
                    chan_vld_d = 1'b1;
                    err_d      = 1'b0;
                end else if (up_press_c ^ dn_press_c) begin
                    // Simultaneous up/down presses cancel; saturated steps stay silent.
                    step_c     = up_press_c ? chan_next(chan_q, CH_LO, CH_HI, WRAP)
                                            : chan_prev(chan_q, CH_LO, CH_HI, WRAP);
                    chan_d     = step_c;
                    chan_vld_d = (step_c != chan_q);
                end
            end
            SET, NEXT: begin
                state_d = DWELL;
                cnt_d   = '0;
            end
            DWELL: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d    = REQ;
                    meas_req_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REQ: begin
                if (meas_ack) begin
                    state_d    = RELEASE;
                    meas_req_d = 1'b0;
                end else if (TMO_EN && cnt_q == TMO_LAST) begin
                    state_d    = RELEASE;
                    meas_req_d = 1'b0;
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!meas_ack) begin
                    if (chan_q == CH_HI) begin
                        state_d    = FIN;
                        chan_d     = CH_DEF_L;
                        chan_vld_d = (chan_q != CH_DEF_L);
                    end else begin
                        state_d    = NEXT;
                        chan_d     = chan_next(chan_q, CH_LO, CH_HI, 1'b0);
                        chan_vld_d = 1'b1;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever the scan was about to do; err is left as is.
        if (state_q != IDLE && abort) begin
            state_d    = IDLE;
            chan_d     = CH_DEF_L;
            chan_vld_d = (chan_q != CH_DEF_L);
            meas_req_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            chan_q     <= CH_DEF_L;
            chan_vld_q <= 1'b0;
            meas_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            chan_vld_q <= chan_vld_d;
            meas_req_q <= meas_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign chan     = chan_q;
    assign chan_vld = chan_vld_q;
    assign meas_req = meas_req_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sw_chan_scan_ctrl.sv
// Bench for sw_chan_scan_ctrl: cycle model of the scan plus directed manual/scan/abort vectors.
// With SW_CHAN_SKIP_MCU_EN defined an extra instance exercises the 14/15 skip.
module tb_sw_chan_scan_ctrl;

    localparam int DB  = 8;
    localparam int DW  = 6;
    localparam int TMO = 100;
    localparam int LO  = 0;
    localparam int HI  = 4;
    localparam int DEF = 0;
`ifdef SW_CHAN_SKIP_MCU_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, up_raw, dn_raw, auto_start, abort, meas_ack;
    logic [7:0] chan;
    logic       chan_vld, meas_req, busy, done, err;
    logic [7:0] s_chan;
    logic       s_vld, s_req, s_busy, s_done, s_err;

    int n_vec = 0;
    int n_err = 0;

    sw_chan_scan_ctrl #(.CH_MIN(LO), .CH_MAX(HI), .CH_DEF(DEF), .WRAP_EN(1), .DB_CYC(DB),
                        .DWELL_CYC(DW), .TMO_CYC(TMO)) u_dut (
        .clk(clk), .rst_n(rst_n), .up_raw(up_raw), .dn_raw(dn_raw), .auto_start(auto_start),
        .abort(abort), .meas_ack(meas_ack), .chan(chan), .chan_vld(chan_vld),
        .meas_req(meas_req), .busy(busy), .done(done), .err(err));

    // Saturating twin sharing the manual switches.
    sw_chan_scan_ctrl #(.CH_MIN(LO), .CH_MAX(HI), .CH_DEF(DEF), .WRAP_EN(0), .DB_CYC(DB),
                        .DWELL_CYC(DW), .TMO_CYC(TMO)) u_sat (
        .clk(clk), .rst_n(rst_n), .up_raw(up_raw), .dn_raw(dn_raw), .auto_start(1'b0),
        .abort(1'b0), .meas_ack(1'b0), .chan(s_chan), .chan_vld(s_vld),
        .meas_req(s_req), .busy(s_busy), .done(s_done), .err(s_err));

`ifdef SW_CHAN_SKIP_MCU_EN
    logic       k_up, k_dn, k_start, k_ack;
    logic [7:0] k_chan;
    logic       k_vld, k_req, k_busy, k_done, k_err;
    sw_chan_scan_ctrl #(.CH_MIN(12), .CH_MAX(17), .CH_DEF(12), .WRAP_EN(1), .DB_CYC(DB),
                        .DWELL_CYC(DW), .TMO_CYC(TMO)) u_skip (
        .clk(clk), .rst_n(rst_n), .up_raw(k_up), .dn_raw(k_dn), .auto_start(k_start),
        .abort(1'b0), .meas_ack(k_ack), .chan(k_chan), .chan_vld(k_vld),
        .meas_req(k_req), .busy(k_busy), .done(k_done), .err(k_err));
`endif

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Legal-channel list stepping: position in the ordered list of selectable channels.
    function automatic int step_list(input int cur, input int lo, input int hi,
                                     input bit up, input bit wrap, input bit skip);
        int lst[$];
        int idx;
        int last;
        for (int c = lo; c <= hi; c++)
            if (!(skip && (c == 14 || c == 15))) lst.push_back(c);
        idx = 0;
        foreach (lst[i]) if (lst[i] == cur) idx = i;
        last = lst.size() - 1;
        if (up) return (idx == last) ? (wrap ? lst[0] : cur) : lst[idx + 1];
        return (idx == 0) ? (wrap ? lst[last] : cur) : lst[idx - 1];
    endfunction

    // Reference model: outputs derived from elapsed cycles since each scan event.
    int m_chan = DEF, m_age = 0, m_rage = 0, m_old = 0;
    bit m_busy = 0, m_req = 0, m_err = 0, m_done = 0, m_vld = 0, m_rel = 0, m_fin = 0;
    bit m_stable = 1, chk_on = 0, man_dir = 0;
    int man_req_cnt = 0, man_seen = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_chan = DEF; m_busy = 0; m_req = 0; m_err = 0; m_done = 0; m_vld = 0;
            m_rel = 0; m_fin = 0; m_age = 0; m_rage = 0; man_seen = man_req_cnt;
        end else begin
            m_vld = 0; m_done = 0;
            if (!m_busy) begin
                if (auto_start && !abort) begin
                    m_busy = 1; m_chan = LO; m_vld = 1; m_err = 0; m_age = 0;
                    m_req = 0; m_rel = 0; m_fin = 0;
                end else if (man_seen != man_req_cnt) begin
                    man_seen = man_req_cnt;
                    m_chan = step_list(m_chan, LO, HI, man_dir, 1'b1, SKIP);
                end
            end else if (abort) begin
                m_old = m_chan; m_chan = DEF; m_vld = (m_old != DEF);
                m_busy = 0; m_req = 0; m_rel = 0; m_fin = 0;
            end else if (m_fin) begin
                m_busy = 0; m_fin = 0;
            end else if (m_req) begin
                m_rage++;
                if (meas_ack) begin
                    m_req = 0; m_rel = 1;
                end else if (TMO != 0 && m_rage == TMO) begin
                    m_err = 1; m_req = 0; m_rel = 1;
                end
            end else if (m_rel) begin
                if (!meas_ack) begin
                    m_rel = 0;
                    if (m_chan == HI) begin
                        m_vld = (m_chan != DEF); m_chan = DEF; m_done = 1; m_fin = 1;
                    end else begin
                        m_chan = step_list(m_chan, LO, HI, 1'b1, 1'b0, SKIP);
                        m_vld = 1; m_age = 0;
                    end
                end
            end else begin
                m_age++;
                if (m_age == DW + 1) begin
                    m_req = 1; m_rage = 0;
                end
            end
        end
    end

    int cnt_vld = 0, cnt_svld = 0, cnt_done = 0;

    // Per-cycle compare against the model; chan/chan_vld skipped while a manual press settles.
    initial begin
        forever begin
            @(negedge clk);
            if (chan_vld) cnt_vld++;
            if (s_vld) cnt_svld++;
            if (done) cnt_done++;
            if (chk_on) begin
                chk("busy", int'(busy), int'(m_busy));
                chk("meas_req", int'(meas_req), int'(m_req));
                chk("done", int'(done), int'(m_done));
                chk("err", int'(err), int'(m_err));
                if (m_stable) begin
                    chk("chan", int'(chan), m_chan);
                    chk("chan_vld", int'(chan_vld), int'(m_vld));
                end
            end
        end
    end

    task automatic set_raw(input bit sel, input bit up, input logic v);
        if (!sel) begin
            if (up) up_raw = v; else dn_raw = v;
        end
`ifdef SW_CHAN_SKIP_MCU_EN
        else begin
            if (up) k_up = v; else k_dn = v;
        end
`endif
    endtask

    // One bouncy press/release; sel 0 = shared main/saturating switches, 1 = skip instance.
    task automatic press(input bit sel, input bit up);
        if (!sel) m_stable = 0;
        for (int i = 0; i < 20; i++) begin
            set_raw(sel, up, ((i / 2) % 2) == 0);
            @(negedge clk);
        end
        set_raw(sel, up, 1'b1);
        repeat (DB + 10) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            set_raw(sel, up, ((i / 2) % 2) == 1);
            @(negedge clk);
        end
        set_raw(sel, up, 1'b0);
        repeat (DB + 10) @(negedge clk);
        if (!sel) begin
            man_dir = up;
            man_req_cnt++;
            @(posedge clk);
            @(negedge clk);
            m_stable = 1;
        end
    endtask

    int meas_q[$];

    task automatic run_scan(input int ack_dly, input bit ack_en, output int nreq, output int ndone,
                            output int lat, output int err_lat, output int err0);
        int since_req, since_vld, req_cyc;
        bit prev_req, got_done, fin;
        nreq = 0; ndone = 0; lat = -1; err_lat = -1; since_req = 0; since_vld = 0;
        req_cyc = -1; prev_req = 0; got_done = 0; fin = 0;
        meas_q.delete();
        auto_start = 1'b1;
        @(negedge clk);
        auto_start = 1'b0;
        err0 = int'(err);
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            since_vld = chan_vld ? 0 : since_vld + 1;
            if (meas_req && !prev_req) begin
                nreq++;
                meas_q.push_back(int'(chan));
                if (lat < 0) lat = since_vld;
                if (req_cyc < 0) req_cyc = cyc;
                since_req = 0;
            end
            if (err && err_lat < 0 && req_cyc >= 0) err_lat = cyc - req_cyc;
            if (meas_req) begin
                since_req++;
                meas_ack = ack_en && (since_req >= ack_dly);
            end else begin
                meas_ack = 1'b0;
            end
            if (done) begin
                ndone++;
                got_done = 1;
            end else if (got_done && !busy) begin
                fin = 1;
            end
            prev_req = meas_req;
            if (!fin) @(negedge clk);
        end
        meas_ack = 1'b0;
        chk("scan_completes", int'(fin), 1);
    endtask

    int nreq, ndone, lat, err_lat, err0;
    int exp_scan[5] = '{0, 1, 2, 3, 4};

    initial begin
        rst_n = 1'b1; up_raw = 0; dn_raw = 0; auto_start = 0; abort = 0; meas_ack = 0;
`ifdef SW_CHAN_SKIP_MCU_EN
        k_up = 0; k_dn = 0; k_start = 0; k_ack = 0;
`endif
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_chan", int'(chan), 0);
        chk("rst_chan_vld", int'(chan_vld), 0);
        chk("rst_meas_req", int'(meas_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
`ifdef SW_CHAN_SKIP_MCU_EN
        chk("rst_skip_chan", int'(k_chan), 12);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk_on = 1;

        // Three bouncy up presses.
        for (int i = 1; i <= 3; i++) begin
            press(0, 1'b1);
            chk("up_chan", int'(chan), i);
            chk("up_sat_chan", int'(s_chan), i);
        end
        chk("up_strobes", cnt_vld, 3);

        // Limits: wrap vs saturate.
        press(0, 1'b1);
        chk("up_to_max", int'(chan), 4);
        press(0, 1'b1);
        chk("wrap_up", int'(chan), 0);
        chk("sat_up_hold", int'(s_chan), 4);
        chk("sat_strobes", cnt_svld, 4);
        press(0, 1'b0);
        chk("wrap_dn", int'(chan), 4);
        chk("sat_dn", int'(s_chan), 3);
        chk("wrap_strobes", cnt_vld, 6);

        // Full scan with acks.
        cnt_done = 0;
        run_scan(10, 1'b1, nreq, ndone, lat, err_lat, err0);
        chk("scan_nreq", nreq, 5);
        chk("scan_done", ndone, 1);
        chk("scan_lat", lat, DW + 1);
        chk("scan_nmeas", meas_q.size(), 5);
        foreach (exp_scan[i]) chk("scan_ch", (i < meas_q.size()) ? meas_q[i] : -1, exp_scan[i]);
        chk("scan_end_chan", int'(chan), 0);
        chk("scan_err", int'(err), 0);

        // No acks: every channel times out, scan still completes.
        run_scan(0, 1'b0, nreq, ndone, lat, err_lat, err0);
        chk("tmo_nreq", nreq, 5);
        chk("tmo_err_lat", err_lat, TMO);
        chk("tmo_done", ndone, 1);
        chk("tmo_err_sticky", int'(err), 1);

        // Restart clears err.
        run_scan(3, 1'b1, nreq, ndone, lat, err_lat, err0);
        chk("restart_err_clr", err0, 0);
        chk("restart_nreq", nreq, 5);

        // Abort in the dwell of channel 2.
        cnt_done = 0;
        auto_start = 1'b1;
        @(negedge clk);
        auto_start = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            meas_ack = meas_req;
            if (m_busy && m_chan == 2 && !m_req && !m_rel && m_age >= 2 && m_age <= 4) break;
            @(negedge clk);
        end
        chk("abort_reached", m_chan, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        meas_ack = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_chan", int'(chan), 0);
        chk("abort_req", int'(meas_req), 0);
        repeat (DW + 5) @(negedge clk);
        chk("abort_no_done", cnt_done, 0);
        chk("abort_idle", int'(busy), 0);

        // Abort beats a simultaneous auto_start in IDLE.
        abort = 1'b1; auto_start = 1'b1;
        @(negedge clk);
        abort = 1'b0; auto_start = 1'b0;
        chk("abort_start_busy", int'(busy), 0);
        chk("abort_start_vld", int'(chan_vld), 0);
        repeat (3) @(negedge clk);

`ifdef SW_CHAN_SKIP_MCU_EN
        begin
            int kq[$];
            int kexp[4] = '{12, 13, 16, 17};
            bit kprev, kfin;
            kprev = 0; kfin = 0;
            k_start = 1'b1;
            @(negedge clk);
            k_start = 1'b0;
            for (int cyc = 0; cyc < 2000 && !kfin; cyc++) begin
                if (k_req && !kprev) kq.push_back(int'(k_chan));
                k_ack = k_req;
                if (k_done) kfin = 1;
                kprev = k_req;
                @(negedge clk);
            end
            k_ack = 1'b0;
            chk("skip_scan_done", int'(kfin), 1);
            chk("skip_nmeas", kq.size(), 4);
            foreach (kexp[i]) chk("skip_ch", (i < kq.size()) ? kq[i] : -1, kexp[i]);
            repeat (2) @(negedge clk);
            chk("skip_end_chan", int'(k_chan), 12);
            press(1, 1'b1);
            chk("skip_up13", int'(k_chan), 13);
            press(1, 1'b1);
            chk("skip_up16", int'(k_chan), 16);
            press(1, 1'b0);
            chk("skip_dn13", int'(k_chan), 13);
        end
`endif

        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
